gps_time_keeper: RTL and testbench
==================================

GPS_TIME_KEEPER -- requirements
Module: gps_time_keeper

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000; system clock frequency in Hz, sets the 1 Hz prescaler terminal count CLK_FREQ-1.
REQ-002 Parameter TZ_OFFSET_H, default 8; local-time hour offset added to UTC, legal range 0..23.
REQ-003 Parameter HOLDOVER_S, default 10; seconds without a valid update before sync is declared lost.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 upd_vld  input  1  one-cycle pulse; hours/minutes/seconds hold a freshly decoded UTC time.
REQ-007 hours  input  16  UTC hours as two ASCII digits; [15:8] tens, [7:0] units.
REQ-008 minutes  input  16  UTC minutes, same format.
REQ-009 seconds  input  16  UTC seconds, same format.
REQ-010 hours_o  output  16  local hours, same two-ASCII-digit format, consumable directly by the 595 display driver.
REQ-011 minutes_o  output  16  local minutes, same format.
REQ-012 seconds_o  output  16  local seconds, same format.
REQ-013 synced  output  1  high while time is GPS-disciplined.
REQ-014 sec_tick  output  1  one-cycle pulse per seconds_o change caused by the internal 1 Hz count.
REQ-015 upd_err  output  1  one-cycle pulse when an upd_vld sample is rejected.

Function
REQ-016 On upd_vld, the block SHALL accept the sample only if all six bytes are 0x30..0x39, hours<24, minutes<60, seconds<60; otherwise upd_err pulses one cycle later and internal state is unchanged.
REQ-017 An accepted sample SHALL load binary counters: sec=seconds, min=minutes, hr=(hours+TZ_OFFSET_H) mod 24; prescaler cleared to 0; synced set; holdover counter cleared.
REQ-018 Outputs SHALL reflect an accepted sample exactly 2 cycles after upd_vld (cycle 1 binary load, cycle 2 binary-to-ASCII register).
REQ-019 Prescaler SHALL count 0..CLK_FREQ-1; on terminal count it wraps to 0 and advances sec.
REQ-020 sec SHALL wrap 59->0 with carry to min; min 59->0 with carry to hr; hr 23->0; no date handling.
REQ-021 sec_tick SHALL assert in the same cycle the advanced value appears on seconds_o.
REQ-022 upd_vld coinciding with prescaler terminal count: accepted update wins, advance and sec_tick suppressed; rejected update does not suppress the advance.
REQ-023 Counting SHALL run from reset regardless of synced (free-running from 00:00:00).
REQ-024 Back-to-back upd_vld on consecutive cycles SHALL each be evaluated; last accepted sample wins.

Reset
REQ-025 rst SHALL set hours_o/minutes_o/seconds_o=16'h3030, synced=0, sec_tick=0, upd_err=0, prescaler, counters and holdover counter =0.
REQ-026 rst asserted mid-count or concurrent with upd_vld SHALL take priority; the sample is discarded.

Configuration
REQ-027 Macro GPS_TIME_KEEPER_HOLDOVER_EN defined: a seconds counter incremented on each internal advance clears synced when it reaches HOLDOVER_S; counting continues.
REQ-028 Macro undefined: no holdover counter; synced stays 1 from first accepted sample until rst; HOLDOVER_S unused.

Structure
REQ-029 Package gps_time_pkg SHALL hold ASCII_ZERO (8'h30), default CLK_FREQ, and functions ascii2bin (16-bit to 0..99) and bin2ascii (0..99 to 16-bit).
REQ-030 Sub-module time_field_counter (parameter MODULUS; load, load value, increment in; value, carry out) SHALL be instantiated three times for sec/min/hr.

Verification (bench CLK_FREQ=10)
REQ-031 Reset, no upd_vld, 600 cycles -> seconds_o 16'h3030->16'h3030 after 60 ticks, minutes_o=16'h3031, synced=0.
REQ-032 upd_vld with "12","34","56", TZ 8 -> 2 cycles later hours_o=16'h3230, minutes_o=16'h3334, seconds_o=16'h3536, synced=1.
REQ-033 Load "23","59","59" with TZ 0, 10 cycles -> 16'h3030/16'h3030/16'h3030, one sec_tick.
REQ-034 upd_vld with hours "2A" or minutes "60" -> upd_err pulse, outputs unchanged.
REQ-035 upd_vld on prescaler terminal cycle -> loaded value shown, no sec_tick, next tick 10 cycles later.
REQ-036 HOLDOVER_EN, HOLDOVER_S=3, one sync then none -> synced falls after 3rd tick; undefined -> synced stays 1.

Source files
------------

// File: rtl/gps_time_pkg.sv
// Shared types, constants and ASCII/binary helpers for the GPS time keeper.
// Contents: ASCII_ZERO, DEFAULT_CLK_FREQ, field_t (0..99 binary), ascii2_t
// (two ASCII digits), hms_ascii_t display payload, is_digit, ascii2bin,
// bin2ascii, sample_ok.
package gps_time_pkg;

  localparam logic [7:0]  ASCII_ZERO       = 8'h30;
  localparam int unsigned DEFAULT_CLK_FREQ = 50_000_000;
  localparam int unsigned FIELD_W          = 7;

  typedef logic [FIELD_W-1:0] field_t;
  typedef logic [15:0]        ascii2_t;

  localparam ascii2_t ASCII_00 = {ASCII_ZERO, ASCII_ZERO};

  // Display payload handed to the 595 driver.
  typedef struct packed {
    ascii2_t hours;
    ascii2_t minutes;
    ascii2_t seconds;
  } hms_ascii_t;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  // Only meaningful when both bytes are ASCII digits.
  function automatic field_t ascii2bin(input ascii2_t a);
    logic [7:0] tens;
    logic [7:0] units;
    tens  = a[15:8] - ASCII_ZERO;
    units = a[7:0] - ASCII_ZERO;
    return FIELD_W'(tens * 8'd10 + units);
  endfunction

  function automatic ascii2_t bin2ascii(input field_t v);
    field_t tens;
    field_t units;
    tens  = v / 7'd10;
    units = v - tens * 7'd10;
    return {ASCII_ZERO + 8'(tens), ASCII_ZERO + 8'(units)};
  endfunction

  // All six bytes are digits and each field is within its range.
  function automatic logic sample_ok(input ascii2_t h, input ascii2_t m,
                                     input ascii2_t s);
    logic digits;
    digits = is_digit(h[15:8]) && is_digit(h[7:0]) &&
             is_digit(m[15:8]) && is_digit(m[7:0]) &&
             is_digit(s[15:8]) && is_digit(s[7:0]);
    return digits && (ascii2bin(h) < 7'd24) && (ascii2bin(m) < 7'd60) &&
           (ascii2bin(s) < 7'd60);
  endfunction

endpackage

// File: rtl/time_field_counter.sv
// Modulo-MODULUS binary counter for one time field (sec, min or hr).
// Ports: clk, rst (sync, active-high), load/load_val (load wins over inc),
// inc (advance by one), value (registered count), carry_c (combinational
// wrap indication, high when inc takes value from MODULUS-1 to 0).
module time_field_counter
  import gps_time_pkg::*;
#(
  parameter int unsigned MODULUS = 60
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  field_t load_val,
  input  logic   inc,
  output field_t value,
  output logic   carry_c
);

  localparam field_t LAST = FIELD_W'(MODULUS - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (inc) begin
      value <= (value == LAST) ? '0 : value + 7'd1;
    end
  end

  assign carry_c = inc && !load && (value == LAST);

endmodule

// File: rtl/gps_time_keeper.sv
// GPS-disciplined local time-of-day keeper with two-ASCII-digit outputs.
// Ports: clk, rst (sync, active-high); upd_vld + hours/minutes/seconds (UTC
// sample, ASCII); hours_o/minutes_o/seconds_o (local time, ASCII, registered);
// synced (GPS-disciplined), sec_tick (pulse with each internal seconds change),
// upd_err (pulse one cycle after a rejected sample).
// Option: define GPS_TIME_KEEPER_HOLDOVER_EN to drop synced after HOLDOVER_S
// internal advances without an accepted sample.
module gps_time_keeper
  import gps_time_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = DEFAULT_CLK_FREQ,
  parameter int unsigned TZ_OFFSET_H = 8,
  parameter int unsigned HOLDOVER_S  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        upd_vld,
  input  logic [15:0] hours,
  input  logic [15:0] minutes,
  input  logic [15:0] seconds,
  output logic [15:0] hours_o,
  output logic [15:0] minutes_o,
  output logic [15:0] seconds_o,
  output logic        synced,
  output logic        sec_tick,
  output logic        upd_err
);

  localparam int unsigned PRESC_W    = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_FREQ - 1);
  localparam field_t      TZ         = FIELD_W'(TZ_OFFSET_H % 24);

  logic [PRESC_W-1:0] presc;
  logic               sample_ok_c;
  logic               accept_c;
  logic               advance_c;
  logic               advance_q;
  logic               synced_q;
  field_t             hr_sum_c;
  field_t             hr_load_c;
  field_t             sec_val;
  field_t             min_val;
  field_t             hr_val;
  logic               sec_carry_c;
  logic               min_carry_c;
  logic               hr_carry_unused;
  hms_ascii_t         disp;

  // Sample qualification; an accepted sample pre-empts a coinciding advance.
  assign sample_ok_c = sample_ok(hours, minutes, seconds);
  assign accept_c    = upd_vld && sample_ok_c;
  assign advance_c   = (presc == PRESC_LAST) && !accept_c;

  // UTC hour plus offset stays below 47, so one conditional subtract is mod 24.
  assign hr_sum_c  = ascii2bin(hours) + TZ;
  assign hr_load_c = (hr_sum_c >= 7'd24) ? hr_sum_c - 7'd24 : hr_sum_c;

  // 1 Hz prescaler, restarted by every accepted sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
    end else if (accept_c || (presc == PRESC_LAST)) begin
      presc <= '0;
    end else begin
      presc <= presc + PRESC_W'(1);
    end
  end

  time_field_counter #(.MODULUS(60)) u_sec (
    .clk      (clk),
    .rst      (rst),
    .load     (accept_c),
    .load_val (ascii2bin(seconds)),
    .inc      (advance_c),
    .value    (sec_val),
    .carry_c  (sec_carry_c)
  );

  time_field_counter #(.MODULUS(60)) u_min (
    .clk      (clk),
    .rst      (rst),
    .load     (accept_c),
    .load_val (ascii2bin(minutes)),
    .inc      (sec_carry_c),
    .value    (min_val),
    .carry_c  (min_carry_c)
  );

  // No date handling: the hour wrap is simply dropped.
  time_field_counter #(.MODULUS(24)) u_hr (
    .clk      (clk),
    .rst      (rst),
    .load     (accept_c),
    .load_val (hr_load_c),
    .inc      (min_carry_c),
    .value    (hr_val),
    .carry_c  (hr_carry_unused)
  );

`ifdef GPS_TIME_KEEPER_HOLDOVER_EN
  logic [31:0] hold_cnt;

  // Count advances since the last accepted sample; lose sync at HOLDOVER_S.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
      synced_q <= 1'b0;
    end else if (accept_c) begin
      hold_cnt <= '0;
      synced_q <= 1'b1;
    end else if (advance_c && synced_q) begin
      hold_cnt <= hold_cnt + 32'd1;
      if ((hold_cnt + 32'd1) >= 32'(HOLDOVER_S)) begin
        synced_q <= 1'b0;
      end
    end
  end
`else
  localparam int unsigned holdover_s_unused = HOLDOVER_S;

  // Without holdover, sync is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      synced_q <= 1'b0;
    end else if (accept_c) begin
      synced_q <= 1'b1;
    end
  end
`endif

  // Second pipeline stage: binary-to-ASCII plus status aligned with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp      <= '{hours: ASCII_00, minutes: ASCII_00, seconds: ASCII_00};
      advance_q <= 1'b0;
      sec_tick  <= 1'b0;
      upd_err   <= 1'b0;
      synced    <= 1'b0;
    end else begin
      disp      <= '{hours: bin2ascii(hr_val), minutes: bin2ascii(min_val),
                     seconds: bin2ascii(sec_val)};
      advance_q <= advance_c;
      sec_tick  <= advance_q;
      upd_err   <= upd_vld && !sample_ok_c;
      synced    <= synced_q;
    end
  end

  assign hours_o   = disp.hours;
  assign minutes_o = disp.minutes;
  assign seconds_o = disp.seconds;

endmodule

// File: tb/tb_gps_time_keeper.sv
// Self-checking bench for gps_time_keeper (CLK_FREQ=10, HOLDOVER_S=3).
// Two instances share stimulus: one with TZ_OFFSET_H=8, one with TZ_OFFSET_H=0.
module tb_gps_time_keeper;

  localparam int unsigned CLK_FREQ = 10;
  localparam int unsigned HOLD_S   = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        upd_vld;
  logic [15:0] hours, minutes, seconds;
  logic [15:0] h8, m8, s8, h0, m0, s0;
  logic        sy8, tk8, er8, sy0, tk0, er0;
  logic [48:0] obs8, obs0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [48:0] v8;
    logic [48:0] v0;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  assign obs8 = {h8, m8, s8, sy8};
  assign obs0 = {h0, m0, s0, sy0};

  gps_time_keeper #(.CLK_FREQ(CLK_FREQ), .TZ_OFFSET_H(8), .HOLDOVER_S(HOLD_S)) dut (
    .clk(clk), .rst(rst), .upd_vld(upd_vld), .hours(hours), .minutes(minutes),
    .seconds(seconds), .hours_o(h8), .minutes_o(m8), .seconds_o(s8),
    .synced(sy8), .sec_tick(tk8), .upd_err(er8));

  gps_time_keeper #(.CLK_FREQ(CLK_FREQ), .TZ_OFFSET_H(0), .HOLDOVER_S(HOLD_S)) dut_z (
    .clk(clk), .rst(rst), .upd_vld(upd_vld), .hours(hours), .minutes(minutes),
    .seconds(seconds), .hours_o(h0), .minutes_o(m0), .seconds_o(s0),
    .synced(sy0), .sec_tick(tk0), .upd_err(er0));

  function automatic logic [15:0] asc(input int v);
    logic [7:0] t, u;
    t = 8'(v / 10) + 8'h30;
    u = 8'(v % 10) + 8'h30;
    return {t, u};
  endfunction

  // Expected display for a UTC time h:m:s with synced flag.
  function automatic void push(input string n, input int h, input int m,
                               input int s, input logic sy);
    exp_t e;
    e.name = n;
    e.v8   = {asc((h + 8) % 24), asc(m), asc(s), sy};
    e.v0   = {asc(h), asc(m), asc(s), sy};
    sb.push_back(e);
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [15:0] h, input logic [15:0] m, input logic [15:0] s);
    hours = h; minutes = m; seconds = s; upd_vld = 1'b1;
  endtask

  task automatic load(input int h, input int m, input int s);
    drive(asc(h), asc(m), asc(s));
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1; upd_vld = 1'b0; load(0, 0, 0); upd_vld = 1'b0;
    cyc(3);
    // Reset state is 00:00:00 on both instances, regardless of offset.
    e.name = "reset"; e.v8 = {16'h3030, 16'h3030, 16'h3030, 1'b0}; e.v0 = e.v8;
    sb.push_back(e);
    e = sb.pop_front();
    checks += 3;
    if (obs8 !== e.v8) begin errors++; $display("FAIL %s tz8 got=%h want=%h", e.name, obs8, e.v8); end
    if (obs0 !== e.v0) begin errors++; $display("FAIL %s tz0 got=%h want=%h", e.name, obs0, e.v0); end
    if ({tk8, er8, tk0, er0} !== 4'b0) begin
      errors++; $display("FAIL reset_pulses got=%b want=0000", {tk8, er8, tk0, er0});
    end
    rst = 1'b0;
  endtask

  task automatic test_free_run();
    exp_t e;
    int   first = -1;
    int   nt = 0;
    for (int k = 1; k <= 60; k++) begin
      e.name = "free_run";
      e.v8 = {16'h3030, asc(k / 60), asc(k % 60), 1'b0};
      e.v0 = e.v8;
      sb.push_back(e);
    end
    for (int c = 1; c <= 601; c++) begin
      cyc(1);
      if (tk8) begin
        nt++;
        if (first < 0) first = c;
        if (sb.size() != 0) begin
          e = sb.pop_front();
          checks += 2;
          if (obs8 !== e.v8) begin errors++; $display("FAIL %s c=%0d tz8 got=%h want=%h", e.name, c, obs8, e.v8); end
          if (obs0 !== e.v0) begin errors++; $display("FAIL %s c=%0d tz0 got=%h want=%h", e.name, c, obs0, e.v0); end
        end
      end
    end
    checks += 2;
    if (first != 11) begin errors++; $display("FAIL free_run_first_tick got=%0d want=11", first); end
    if (nt != 60) begin errors++; $display("FAIL free_run_ticks got=%0d want=60", nt); end
    sb.delete();
  endtask

  task automatic test_update();
    exp_t e;
    int   tab[2][3] = '{'{12, 34, 56}, '{20, 7, 9}};
    int   prev[3]   = '{0, 1, 0};
    logic prev_sy   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      // Display must hold the old value one cycle after upd_vld.
      e.name = "upd_hold";
      e.v8 = {(i == 0) ? asc(prev[0]) : asc((prev[0] + 8) % 24), asc(prev[1]), asc(prev[2]), prev_sy};
      e.v0 = {asc(prev[0]), asc(prev[1]), asc(prev[2]), prev_sy};
      sb.push_back(e);
      push("upd_load", tab[i][0], tab[i][1], tab[i][2], 1'b1);
      load(tab[i][0], tab[i][1], tab[i][2]);
      cyc(1);
      upd_vld = 1'b0;
      e = sb.pop_front();
      checks += 3;
      if (obs8 !== e.v8) begin errors++; $display("FAIL %s tz8 got=%h want=%h", e.name, obs8, e.v8); end
      if (obs0 !== e.v0) begin errors++; $display("FAIL %s tz0 got=%h want=%h", e.name, obs0, e.v0); end
      if (er8 !== 1'b0) begin errors++; $display("FAIL upd_err_on_good got=%b want=0", er8); end
      cyc(1);
      e = sb.pop_front();
      checks += 2;
      if (obs8 !== e.v8) begin errors++; $display("FAIL %s tz8 got=%h want=%h", e.name, obs8, e.v8); end
      if (obs0 !== e.v0) begin errors++; $display("FAIL %s tz0 got=%h want=%h", e.name, obs0, e.v0); end
      prev = tab[i]; prev_sy = 1'b1;
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    push("wrap_load", 23, 59, 59, 1'b1);
    push("wrap_tick", 0, 0, 0, 1'b1);
    load(23, 59, 59);
    for (int c = 1; c <= 12; c++) begin
      cyc(1);
      if (c == 1) upd_vld = 1'b0;
      checks++;
      if (tk8 !== (c == 12)) begin errors++; $display("FAIL wrap_tick c=%0d got=%b want=%b", c, tk8, (c == 12)); end
      if (c == 2 || c == 12) begin
        e = sb.pop_front();
        checks += 2;
        if (obs8 !== e.v8) begin errors++; $display("FAIL %s tz8 got=%h want=%h", e.name, obs8, e.v8); end
        if (obs0 !== e.v0) begin errors++; $display("FAIL %s tz0 got=%h want=%h", e.name, obs0, e.v0); end
      end
    end
  endtask

  task automatic test_reject();
    exp_t        e;
    logic [15:0] bad[5][3] = '{'{16'h3241, 16'h3030, 16'h3030},   // hours "2A"
                               '{16'h3132, 16'h3630, 16'h3030},   // minutes "60"
                               '{16'h3234, 16'h3030, 16'h3030},   // hours "24"
                               '{16'h3132, 16'h3030, 16'h352F},   // seconds "5/"
                               '{16'h3132, 16'h3A30, 16'h3030}};  // minutes ":0"
    push("reject_hold", 10, 20, 30, 1'b1);
    push("reject_tick", 10, 20, 31, 1'b1);
    load(10, 20, 30);
    for (int c = 1; c <= 12; c++) begin
      cyc(1);
      checks += 2;
      if (er8 !== (c >= 2 && c <= 6)) begin errors++; $display("FAIL reject_err c=%0d got=%b want=%b", c, er8, (c >= 2 && c <= 6)); end
      if (tk8 !== (c == 12)) begin errors++; $display("FAIL reject_tick c=%0d got=%b want=%b", c, tk8, (c == 12)); end
      if (c <= 5) drive(bad[c-1][0], bad[c-1][1], bad[c-1][2]);
      else upd_vld = 1'b0;
      if (c == 8 || c == 12) begin
        e = sb.pop_front();
        checks += 2;
        if (obs8 !== e.v8) begin errors++; $display("FAIL %s tz8 got=%h want=%h", e.name, obs8, e.v8); end
        if (obs0 !== e.v0) begin errors++; $display("FAIL %s tz0 got=%h want=%h", e.name, obs0, e.v0); end
      end
    end
  endtask

  task automatic test_terminal();
    exp_t e;
    push("term_first", 1, 2, 3, 1'b1);
    push("term_load", 4, 5, 6, 1'b1);
    push("term_next", 4, 5, 7, 1'b1);
    push("term_rej", 4, 5, 8, 1'b1);
    load(1, 2, 3);
    for (int c = 1; c <= 32; c++) begin
      cyc(1);
      checks += 2;
      if (tk8 !== (c == 22 || c == 32)) begin errors++; $display("FAIL term_tick c=%0d got=%b want=%b", c, tk8, (c == 22 || c == 32)); end
      if (er8 !== (c == 31)) begin errors++; $display("FAIL term_err c=%0d got=%b want=%b", c, er8, (c == 31)); end
      if (c == 1 || c == 11 || c == 31) upd_vld = 1'b0;
      if (c == 10) load(4, 5, 6);
      if (c == 30) drive(16'h3241, 16'h3030, 16'h3030);
      if (c == 11 || c == 12 || c == 22 || c == 32) begin
        e = sb.pop_front();
        checks += 2;
        if (obs8 !== e.v8) begin errors++; $display("FAIL %s tz8 got=%h want=%h", e.name, obs8, e.v8); end
        if (obs0 !== e.v0) begin errors++; $display("FAIL %s tz0 got=%h want=%h", e.name, obs0, e.v0); end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    push("b2b_a", 1, 2, 3, 1'b1);
    push("b2b_b", 4, 5, 6, 1'b1);
    push("b2b_c", 5, 6, 7, 1'b1);
    push("b2b_c_kept", 5, 6, 7, 1'b1);
    load(1, 2, 3);
    for (int c = 1; c <= 5; c++) begin
      cyc(1);
      checks++;
      if (er8 !== (c == 4)) begin errors++; $display("FAIL b2b_err c=%0d got=%b want=%b", c, er8, (c == 4)); end
      if (c == 1) load(4, 5, 6);
      if (c == 2) load(5, 6, 7);
      if (c == 3) drive(16'h3132, 16'h3630, 16'h3030);
      if (c == 4) upd_vld = 1'b0;
      if (c >= 2) begin
        e = sb.pop_front();
        checks += 2;
        if (obs8 !== e.v8) begin errors++; $display("FAIL %s tz8 got=%h want=%h", e.name, obs8, e.v8); end
        if (obs0 !== e.v0) begin errors++; $display("FAIL %s tz0 got=%h want=%h", e.name, obs0, e.v0); end
      end
    end
  endtask

  task automatic test_holdover();
    exp_t e;
    logic want_sy;
    logic hold_en;
`ifdef GPS_TIME_KEEPER_HOLDOVER_EN
    hold_en = 1'b1;
`else
    hold_en = 1'b0;
`endif
    push("hold_end", 0, 0, 5, !hold_en);
    load(0, 0, 0);
    for (int c = 1; c <= 52; c++) begin
      cyc(1);
      if (c == 1) upd_vld = 1'b0;
      if (c >= 2) begin
        want_sy = hold_en ? (c < 32) : 1'b1;
        checks += 2;
        if (sy8 !== want_sy) begin errors++; $display("FAIL hold_synced c=%0d got=%b want=%b", c, sy8, want_sy); end
        if (tk8 !== (c >= 12 && c % 10 == 2)) begin errors++; $display("FAIL hold_tick c=%0d got=%b want=%b", c, tk8, (c >= 12 && c % 10 == 2)); end
      end
    end
    e = sb.pop_front();
    checks += 2;
    if (obs8 !== e.v8) begin errors++; $display("FAIL %s tz8 got=%h want=%h", e.name, obs8, e.v8); end
    if (obs0 !== e.v0) begin errors++; $display("FAIL %s tz0 got=%h want=%h", e.name, obs0, e.v0); end
  endtask

  task automatic test_reset_priority();
    exp_t e;
    cyc(3);
    e.name = "rst_prio"; e.v8 = {16'h3030, 16'h3030, 16'h3030, 1'b0}; e.v0 = e.v8;
    sb.push_back(e);
    sb.push_back(e);
    rst = 1'b1;
    load(11, 11, 11);
    cyc(1);
    rst = 1'b0; upd_vld = 1'b0;
    checks++;
    if ({er8, tk8} !== 2'b00) begin errors++; $display("FAIL rst_prio_pulses got=%b want=00", {er8, tk8}); end
    for (int k = 0; k < 2; k++) begin
      cyc(k == 0 ? 2 : 3);
      e = sb.pop_front();
      checks += 2;
      if (obs8 !== e.v8) begin errors++; $display("FAIL %s tz8 got=%h want=%h", e.name, obs8, e.v8); end
      if (obs0 !== e.v0) begin errors++; $display("FAIL %s tz0 got=%h want=%h", e.name, obs0, e.v0); end
    end
  endtask

  initial begin
    rst = 1'b1; upd_vld = 1'b0;
    hours = 16'h3030; minutes = 16'h3030; seconds = 16'h3030;
    #1;
    test_reset();
    test_free_run();
    test_update();
    test_wrap();
    test_reject();
    test_terminal();
    test_back_to_back();
    test_holdover();
    test_reset_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
